// File: rtl/amo_rmw_arbiter.sv
// amo_rmw_arbiter: round-robin arbiter that serialises atomic read-modify-write
// requests onto one shared atomic ALU and one memory port.
// Each grant runs read -> ALU -> write-back -> respond, with a
// reservation-clear pulse when the store is acknowledged.
//
// state | meaning
// IDLE  | arbitrate; a one-hot req_ready accepts the winning request
// READ  | memory read of the old word; old_q is loaded on mem_ack
// WRITE | write alu_rd back; clear_reservation pulses on mem_ack
// RESP  | one-cycle rsp_valid to the owner with the old value
module amo_rmw_arbiter #(
  parameter int NUM_UNITS = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_UNITS-1:0]      req_valid,
  output logic [NUM_UNITS-1:0]      req_ready,
  input  logic [NUM_UNITS-1:0][4:0] req_op,
  input  logic [NUM_UNITS-1:0][31:0] req_addr,
  input  logic [NUM_UNITS-1:0][31:0] req_data,
  output logic [NUM_UNITS-1:0]      rsp_valid,
  output logic [31:0]               rsp_data,
  output logic [4:0]                alu_op,
  output logic [31:0]               alu_rs1,
  output logic [31:0]               alu_rs2,
  input  logic [31:0]               alu_rd,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [31:0]               mem_addr,
  output logic [31:0]               mem_wdata,
  input  logic                      mem_ack,
  input  logic [31:0]               mem_rdata,
  output logic                      clear_reservation,
  output logic                      busy
);

  localparam int IW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner_q;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] next_ptr;
  logic          grant_found;
  logic [4:0]    op_q;
  logic [31:0]   addr_q;
  logic [31:0]   data_q;
  logic [31:0]   old_q;

  // Rotating priority search: first requester at or after rr_ptr, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < NUM_UNITS; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_UNITS) cand = cand - NUM_UNITS;
      if (!grant_found && req_valid[IW'(cand)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(cand);
      end
    end
  end

  assign next_ptr = (grant_idx == IW'(NUM_UNITS - 1)) ? '0 : grant_idx + 1'b1;

  // Accept pulse only while idle; suppressed during reset so nothing is captured.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && grant_found && !rst) req_ready[grant_idx] = 1'b1;
  end

  // The ALU always sees the registered operands, so alu_rd is steady through WRITE.
  assign alu_op    = op_q;
  assign alu_rs1   = old_q;
  assign alu_rs2   = data_q;
  assign mem_addr  = addr_q & 32'hFFFF_FFFC;
  assign mem_wdata = mem_we ? alu_rd : 32'h0;

  // Must coincide with the write acknowledge, hence not registered.
  assign clear_reservation = (state == WRITE) && mem_ack && !rst;

  // Sequencer: arbitration capture, memory handshakes and response pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner_q   <= '0;
      op_q      <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      old_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      busy      <= 1'b0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            owner_q <= grant_idx;
            op_q    <= req_op[grant_idx];
            addr_q  <= req_addr[grant_idx];
            data_q  <= req_data[grant_idx];
            rr_ptr  <= next_ptr;
            mem_req <= 1'b1;
            mem_we  <= 1'b0;
            busy    <= 1'b1;
            state   <= READ;
          end
        end
        READ: begin
          if (mem_ack) begin
            old_q  <= mem_rdata;
            mem_we <= 1'b1;
            state  <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            rsp_valid <= NUM_UNITS'(1) << owner_q;
            rsp_data  <= old_q;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          rsp_data  <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/amo_rmw_arbiter.md
Name: amo_rmw_arbiter

Overview:
Arbitrates atomic read-modify-write (AMO) requests from NUM_UNITS load/store requesters onto the single shared atomic ALU and the single memory port. For each granted request it sequences three steps: read the old word, compute with the combinational atomic ALU, then write the result back. It returns the old value to the requester and pulses a reservation-clear so that any outstanding LR/SC reservation is invalidated by the store.

Parameters:
NUM_UNITS, 3, number of requesters (>=1)

Ports:
clk  input  1  clock
rst  input  1  reset; synchronous, active-high
req_valid  input  NUM_UNITS  per-unit AMO request; held until accepted
req_ready  output  NUM_UNITS  one-hot accept pulse; request captured this cycle
req_op  input  NUM_UNITS x 5  per-unit amo_t operation encoding
req_addr  input  NUM_UNITS x 32  per-unit word address (bits 1:0 ignored)
req_data  input  NUM_UNITS x 32  per-unit rs2 operand
rsp_valid  output  NUM_UNITS  one-hot, one-cycle completion pulse to the owning unit
rsp_data  output  32  old memory value; valid when any rsp_valid is high
alu_op  output  5  operation to the shared atomic ALU
alu_rs1  output  32  ALU operand 1 (old memory value)
alu_rs2  output  32  ALU operand 2 (captured req_data)
alu_rd  input  32  combinational ALU result
mem_req  output  1  memory access request; held until mem_ack
mem_we  output  1  1 = write, 0 = read
mem_addr  output  32  word address, {addr_q[31:2],2'b00}
mem_wdata  output  32  write data
mem_ack  input  1  access complete; read data valid on the same cycle
mem_rdata  input  32  read data
clear_reservation  output  1  one-cycle pulse when the write is acknowledged
busy  output  1  high in any state other than IDLE

Behaviour:
- State machine: IDLE, READ, WRITE, RESP. Reset puts it in IDLE with rr_ptr=0.
- Reset values: all outputs 0, including req_ready, rsp_valid, mem_req, mem_we, clear_reservation and busy.
- IDLE, arbitration:
  - Round-robin: grant the lowest index i >= rr_ptr with req_valid[i]; if none, wrap and take the lowest index < rr_ptr.
  - Grant cycle: req_ready[i]=1 combinationally. Capture op_q, addr_q, data_q and owner_q=i. Set rr_ptr = (i+1) mod NUM_UNITS. Next state READ.
  - No req_valid: stay in IDLE with req_ready=0.
- req_ready is only ever asserted in IDLE, and at most one bit is high.
- READ:
  - mem_req=1, mem_we=0, mem_addr from addr_q.
  - On mem_ack, capture old_q=mem_rdata and go to WRITE.
- WRITE:
  - mem_req=1, mem_we=1, mem_wdata=alu_rd.
  - ALU inputs: alu_op=op_q, alu_rs1=old_q, alu_rs2=data_q. These are driven from the registers in every state so alu_rd is stable for the whole WRITE state.
  - On mem_ack: clear_reservation=1 for that cycle, then go to RESP.
- RESP: rsp_valid[owner_q]=1 and rsp_data=old_q for exactly one cycle, then IDLE.
- Minimum latency with 0-wait memory (ack in the same cycle as req): grant T0, READ T1, WRITE T2, RESP T3, next grant possible at T4.
- mem_req and mem_addr/mem_we/mem_wdata stay stable until mem_ack. mem_ack while mem_req=0 is ignored.
- Requests arriving while busy are not accepted; each requester keeps req_valid asserted until it sees req_ready.
- A requester dropping req_valid before grant is legal and loses its turn without affecting rr_ptr.
- Reset mid-operation: return to IDLE on the next edge, drop mem_req, emit no rsp_valid and no clear_reservation, rr_ptr=0. A stale mem_ack after reset is ignored.
- NUM_UNITS=1: rr_ptr stays 0. Index widths use max(1, clog2(NUM_UNITS)).

Test Plan:
- Single op, 0-wait memory: unit1 AMOADD, addr 0x100, data 5, mem_rdata 10 -> req_ready=3'b010 at T0; write of 15 to 0x100 at T2 with clear_reservation=1; rsp_valid=3'b010, rsp_data=10 at T3.
- Wait states: AMOSWAP with mem_ack delayed 3 cycles on both the read and the write -> mem_req/mem_addr/mem_we stable throughout; exactly one clear_reservation pulse; rsp_data equals the read value.
- Round-robin: all three units request continuously from reset -> grant order 0,1,2,0,1,2; each unit receives its own rsp_valid.
- Pointer wrap/skip: after unit2 is granted, only unit1 requests -> unit1 granted; then units 0 and 1 request together -> unit0 granted first, then unit1.
- Reset in WRITE: assert rst while mem_req=1, mem_we=1 -> next cycle all outputs 0 and IDLE; a late mem_ack produces no rsp_valid; the next request is granted normally.
- ALU wiring: AMOMAXU with old value 0xFFFF_FFFF and data 1 -> mem_wdata=0xFFFF_FFFF; AMOAND with 0xF0F0 and 0x0FF0 -> 0x00F0.
